// File: rtl/frame_scanout.sv
// ---------------------------------------------------------------------------
// frame_scanout
//   Display-side consumer of the VGA double buffer. Generates 640x480@60
//   raster timing on a pixel-clock enable, issues framebuffer word addresses
//   for a 160x120 buffer scaled up 4x in each direction, aligns the returned
//   read data with the delayed sync/blank timing, and pulses disp_done once
//   per frame when the last active line has been shown, so the buffer swap
//   lands in vertical blanking.
//
//   Optional feature: define VGA_TEST_PATTERN_EN to add a test_mode input
//   that replaces the picture with eight vertical colour bars.
// ---------------------------------------------------------------------------
module frame_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = 160,
    parameter int PIPE        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [14:0] read_address,
    input  logic [23:0] read_data,
    output logic        disp_done,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n
`ifdef VGA_TEST_PATTERN_EN
    ,
    input  logic        test_mode
`endif
);

    // -----------------------------------------------------------------------
    // Derived geometry. Every compare constant is sized to its counter so the
    // comparisons are width-exact.
    // -----------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = 15;

    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DONE   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [AW-1:0] ROW_STEP = AW'(FB_W);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [HW-1:0]          h_cnt;
    logic [VW-1:0]          v_cnt;
    logic [AW-1:0]          row_base;
    logic [SCALE_SHIFT-1:0] line_sub;

    // Stage-0 timing decoded straight from the counters.
    logic active_s0;
    logic hs_n_s0;
    logic vs_n_s0;
    logic line_end;
    logic frame_end;

    // Alignment pipeline: bit 0 is the newest pixel, bit PIPE-1 the oldest.
    logic [PIPE-1:0] act_pipe;
    logic [PIPE-1:0] hs_pipe;
    logic [PIPE-1:0] vs_pipe;

    logic [23:0] pixel_rgb;
    logic [23:0] rgb_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_s0;
    logic [2:0] bar_pipe [PIPE];

    // Colour for each of the eight bars, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFF_FF_FF;  // white
            3'd1:    return 24'hFF_FF_00;  // yellow
            3'd2:    return 24'h00_FF_FF;  // cyan
            3'd3:    return 24'h00_FF_00;  // green
            3'd4:    return 24'hFF_00_FF;  // magenta
            3'd5:    return 24'hFF_00_00;  // red
            3'd6:    return 24'h00_00_FF;  // blue
            default: return 24'h00_00_00;  // black
        endcase
    endfunction
`endif

    // Decode raster position into active/sync flags and wrap conditions.
    // NOTE: every signal assigned in an always_comb gets a value on every
    // path (here by construction, elsewhere by a default first) so that no
    // latch is inferred.
    always_comb begin
        active_s0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_n_s0   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_n_s0   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        line_end  = (h_cnt == H_LAST);
        frame_end = line_end && (v_cnt == V_LAST);
    end

    // Horizontal and vertical raster counters, advancing once per pixel.
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values and the order of statements is moot.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= frame_end ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // Framebuffer address generation. The row base is accumulated in steps
    // of FB_W every 2^SCALE_SHIFT active lines, so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_address <= '0;
            row_base     <= '0;
            line_sub     <= '0;
        end else if (pix_en) begin
            read_address <= active_s0 ? row_base + AW'(h_cnt >> SCALE_SHIFT) : '0;
            if (line_end) begin
                if (v_cnt == V_LAST) begin
                    row_base <= '0;
                    line_sub <= '0;
                end else if (v_cnt < V_ACT) begin
                    line_sub <= line_sub + SCALE_SHIFT'(1);
                    if (line_sub == '1) begin
                        row_base <= row_base + ROW_STEP;
                    end
                end
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Bars are H_ACTIVE/8 wide, which is not a power of two, so the bar index
    // comes from a comparator ladder on h_cnt rather than from its top bits.
    always_comb begin
        bar_s0 = '0;
        for (int b = 1; b < 8; b++) begin
            if (h_cnt >= HW'(b * BAR_W)) begin
                bar_s0 = 3'(b);
            end
        end
    end
`endif

    // Delay the stage-0 timing flags so they line up with returned read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
`ifdef VGA_TEST_PATTERN_EN
            for (int i = 0; i < PIPE; i++) begin
                bar_pipe[i] <= '0;
            end
`endif
        end else if (pix_en) begin
            act_pipe[0] <= active_s0;
            hs_pipe[0]  <= hs_n_s0;
            vs_pipe[0]  <= vs_n_s0;
            for (int i = 1; i < PIPE; i++) begin
                act_pipe[i] <= act_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
`ifdef VGA_TEST_PATTERN_EN
            bar_pipe[0] <= bar_s0;
            for (int i = 1; i < PIPE; i++) begin
                bar_pipe[i] <= bar_pipe[i-1];
            end
`endif
        end
    end

    // Pick the colour source for the pixel at the end of the pipeline.
    always_comb begin
        pixel_rgb = read_data;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            pixel_rgb = bar_colour(bar_pipe[PIPE-1]);
        end
`endif
    end

    // Output stage: register sync/blank and colour, black outside active video.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_blank_n <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            rgb_q       <= '0;
        end else if (pix_en) begin
            vga_blank_n <= act_pipe[PIPE-1];
            vga_hs      <= hs_pipe[PIPE-1];
            vga_vs      <= vs_pipe[PIPE-1];
            rgb_q       <= act_pipe[PIPE-1] ? pixel_rgb : '0;
        end
    end

    assign vga_r = rgb_q[23:16];
    assign vga_g = rgb_q[15:8];
    assign vga_b = rgb_q[7:0];

    // One-clk end-of-active-frame pulse; it self-clears on the next clk edge
    // whether or not that edge carries a pixel enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_done <= 1'b0;
        end else begin
            disp_done <= pix_en && line_end && (v_cnt == V_DONE);
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// ---------------------------------------------------------------------------
// tb_frame_scanout
//   Scoreboard bench for frame_scanout. Horizontal timing is the full 800-pixel
//   line; the vertical geometry is shortened to 6 active lines in a 10-line
//   frame so several frames fit in a short run. A 3-clk RAM model returns
//   data equal to the address. The stimulus process pushes expected values
//   per pixel; a monitor on the falling clock edge pops and compares.
// ---------------------------------------------------------------------------
module tb_frame_scanout;

    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 6;
    localparam int V_TOTAL  = 10;

    typedef struct packed {
        logic [14:0] addr;
        logic        done;
        int          h;
        int          v;
        int          frame;
    } addr_exp_t;

    typedef struct packed {
        logic        blank_n;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
        int          h;
        int          v;
        int          frame;
    } out_exp_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        pix_en = 1'b0;
    logic [14:0] read_address;
    logic [23:0] read_data = '0;
    logic        disp_done;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;

    addr_exp_t addr_q[$];
    out_exp_t  out_q[$];

    int n_vec     = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;

    // Raster position of the next pixel the stimulus will issue.
    int m_h     = 0;
    int m_v     = 0;
    int m_frame = 0;

    // Frame-0 statistics gathered from the DUT outputs.
    int blank_cnt  = 0;
    int hs_low_cnt = 0;
    int hs_first   = -1;
    int vs_low_cnt = 0;
    logic stats_done = 1'b0;

    logic was_pix = 1'b0;
    logic was_rst = 1'b0;

    // Hand-computed address points for frame 0: {x, y, address}.
    int dir_h [7] = '{0, 3, 4, 0,   639, 640, 0};
    int dir_v [7] = '{0, 3, 0, 4,   5,   0,   6};
    int dir_a [7] = '{0, 0, 1, 160, 319, 0,   0};

    frame_scanout #(
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_en       (pix_en),
        .read_address (read_address),
        .read_data    (read_data),
        .disp_done    (disp_done),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_blank_n  (vga_blank_n)
    );

    always #5 clk = ~clk;

    // Double-buffer read port model: 3-clk latency, data equals address.
    logic [14:0] ram_a1 = '0;
    logic [14:0] ram_a2 = '0;
    always @(posedge clk) begin
        ram_a1    <= read_address;
        ram_a2    <= ram_a1;
        read_data <= {9'd0, ram_a2};
    end

    // Remember what kind of edge just happened for the monitor.
    always @(posedge clk) begin
        was_pix <= pix_en;
        was_rst <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic pe);
        pix_en = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle();
        out_exp_t o;
        o.blank_n = 1'b0;
        o.hs      = 1'b1;
        o.vs      = 1'b1;
        o.rgb     = '0;
        o.h       = -1;
        o.v       = -1;
        o.frame   = -1;
        out_q.push_back(o);
    endtask

    // Issue one pixel period (pix_en every 2nd clk) and queue its expectations.
    task automatic pixel();
        addr_exp_t a;
        out_exp_t  o;
        logic      act;
        act     = (m_h < 640) && (m_v < V_ACTIVE);
        a.addr  = act ? 15'((m_v / 4) * 160 + (m_h / 4)) : 15'd0;
        a.done  = (m_h == H_TOTAL - 1) && (m_v == V_ACTIVE - 1);
        a.h     = m_h;
        a.v     = m_v;
        a.frame = m_frame;
        addr_q.push_back(a);
        o.blank_n = act;
        o.hs      = !((m_h >= 656) && (m_h < 752));
        o.vs      = !((m_v >= 7) && (m_v < 9));
        o.rgb     = act ? {9'd0, a.addr} : 24'd0;
        o.h       = m_h;
        o.v       = m_v;
        o.frame   = m_frame;
        out_q.push_back(o);
        step(1'b1);
        step(1'b0);
        m_h++;
        if (m_h == H_TOTAL) begin
            m_h = 0;
            m_v++;
            if (m_v == V_TOTAL) begin
                m_v = 0;
                m_frame++;
            end
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard after every edge.
    always @(negedge clk) begin
        addr_exp_t a;
        out_exp_t  o;
        if (disp_done) pulse_cnt++;
        if (was_rst) begin
            check("rst_read_address", read_address, 0);
            check("rst_disp_done", disp_done, 0);
            check("rst_outputs", {vga_blank_n, vga_hs, vga_vs, vga_r, vga_g, vga_b},
                  {1'b0, 1'b1, 1'b1, 24'h0});
        end else if (was_pix) begin
            if (addr_q.size() == 0 || out_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue, expected a pending entry");
            end else begin
                a = addr_q.pop_front();
                o = out_q.pop_front();
                check($sformatf("addr f%0d (%0d,%0d)", a.frame, a.h, a.v), read_address, a.addr);
                check($sformatf("disp_done f%0d (%0d,%0d)", a.frame, a.h, a.v), disp_done, a.done);
                for (int i = 0; i < 7; i++) begin
                    if (a.frame == 0 && a.h == dir_h[i] && a.v == dir_v[i]) begin
                        check($sformatf("dir_addr (%0d,%0d)", dir_h[i], dir_v[i]),
                              read_address, dir_a[i]);
                    end
                end
                check($sformatf("pixel f%0d (%0d,%0d)", o.frame, o.h, o.v),
                      {vga_blank_n, vga_hs, vga_vs, vga_r, vga_g, vga_b},
                      {o.blank_n, o.hs, o.vs, o.rgb});
                if (o.frame == 0) begin
                    if (vga_blank_n) blank_cnt++;
                    if (!vga_vs) vs_low_cnt++;
                    if (o.v == 0 && !vga_hs) begin
                        hs_low_cnt++;
                        if (hs_first < 0) hs_first = o.h;
                    end
                    if (o.h == H_TOTAL - 1 && o.v == V_TOTAL - 1) begin
                        check("frame0_blank_pixels", blank_cnt, 640 * V_ACTIVE);
                        check("line0_hs_low_periods", hs_low_cnt, 96);
                        check("line0_hs_first_x", hs_first, 656);
                        check("frame0_vs_low_periods", vs_low_cnt, 2 * H_TOTAL);
                        stats_done = 1'b1;
                    end
                end
            end
        end else begin
            check("disp_done_off_enable", disp_done, 0);
        end
    end

    initial begin
        // Reset with pix_en toggling; rst wins over pix_en.
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        rst = 1'b0;
        push_idle();
        push_idle();

        // Two full frames, then the third frame up to line 3.
        while (!(m_frame == 2 && m_v == 3)) pixel();

        // Mid-frame reset, asserted together with pix_en.
        rst = 1'b1;
        addr_q.delete();
        out_q.delete();
        step(1'b1);
        step(1'b0);
        rst = 1'b0;
        push_idle();
        push_idle();
        m_h     = 0;
        m_v     = 0;
        m_frame = 3;

        // One complete frame after the reset, plus a few pixels of the next.
        while (!(m_frame == 4 && m_h == 4)) pixel();
        step(1'b0);
        step(1'b0);

        check("disp_done_pulses", pulse_cnt, 3);
        check("frame0_stats_reached", stats_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
